seq_div: RTL

Sequential unsigned divider; the inverse of the multiply-accumulate datapath. Takes a 2*WIDTH-bit dividend (typically a MAC accumulator value) and a WIDTH-bit divisor, and produces quotient and remainder via a radix-2 restoring algorithm, one quotient bit per clock. It uses a start/busy/done handshake so it can sit beside the MAC and normalise or average its result without a combinational divider.

---
 rtl/seq_div_pkg.sv | 16 +
 rtl/seq_div_if.sv | 26 ++
 rtl/seq_div_step.sv | 27 ++
 rtl/seq_div.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Iteration counter has to hold the value 2*width.
   function automatic int cnt_width(input int width);
      return $clog2(2 * width + 1);
   endfunction

endpackage

// File: rtl/seq_div_if.sv
// Start/busy/done handshake and operand/result bus for seq_div.
// The requester uses the master modport; the divider uses the slave modport.
interface seq_div_if #(
   parameter int WIDTH = 8
) ();

   logic                   start;
   logic [2*WIDTH-1:0]     dividend;
   logic [WIDTH-1:0]       divisor;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     quotient;
   logic [WIDTH-1:0]       remainder;
   logic                   div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/seq_div_step.sv
// One combinational radix-2 restoring iteration.
// The partial remainder is carried as WIDTH bits: its extra top bit only
// exists transiently after the shift and is consumed by the compare here.
// With a zero divisor the truncated difference just drops a bit that the
// next shift would discard anyway, so the final remainder is unaffected.
module seq_div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] r_in,
   input  logic             msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] r_next,
   output logic             q_bit
);

   logic [WIDTH:0]   r_shift;
   logic [WIDTH-1:0] diff;

   // Shift in the dividend MSB, trial-subtract, restore on underflow.
   always_comb begin
      r_shift = {r_in, msb};
      diff    = r_shift[WIDTH-1:0] - divisor;
      q_bit   = (r_shift >= {1'b0, divisor});
      r_next  = q_bit ? diff : r_shift[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned divider, one quotient bit per clock.
// Optional feature macro: SEQ_DIV_ZERO_CHECK_EN (short-circuits divide by zero).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results held; start accepted here only
// RUN   | one iteration per clock; counter 2*WIDTH..1, done after last
module seq_div
   import seq_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic        clk,
   input  logic        reset,
   seq_div_if.slave    bus
);

   localparam int CW = cnt_width(WIDTH);

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q;
   logic [2*WIDTH-1:0]    shreg_q;
   logic [WIDTH-1:0]      divisor_q;
   logic [WIDTH-1:0]      rem_q;
   logic [2*WIDTH-1:0]    quotient_q;
   logic [WIDTH-1:0]      remainder_q;
   logic                  done_q;

   logic                  load;
   logic                  step_en;
   logic                  finish;
   logic [WIDTH-1:0]      r_next;
   logic                  q_bit;
   logic [2*WIDTH-1:0]    shreg_next;

`ifdef SEQ_DIV_ZERO_CHECK_EN
   logic                  zero_done;
   logic                  dbz_q;
`endif

   seq_div_step #(.WIDTH(WIDTH)) u_step (
      .r_in    (rem_q),
      .msb     (shreg_q[2*WIDTH-1]),
      .divisor (divisor_q),
      .r_next  (r_next),
      .q_bit   (q_bit)
   );

   // Quotient bits fill the dividend LSBs as the dividend shifts out.
   assign shreg_next = {shreg_q[2*WIDTH-2:0], q_bit};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step_en = 1'b0;
      finish  = 1'b0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
      zero_done = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
`ifdef SEQ_DIV_ZERO_CHECK_EN
               if (bus.divisor == '0) begin
                  zero_done = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_d = RUN;
               end
`else
               load    = 1'b1;
               state_d = RUN;
`endif
            end
         end
         RUN: begin
            step_en = 1'b1;
            if (cnt_q == CW'(1)) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand, iteration and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         shreg_q     <= '0;
         divisor_q   <= '0;
         rem_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
         dbz_q       <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (load) begin
            shreg_q   <= bus.dividend;
            divisor_q <= bus.divisor;
            rem_q     <= '0;
            cnt_q     <= CW'(2 * WIDTH);
         end else if (step_en) begin
            shreg_q <= shreg_next;
            rem_q   <= r_next;
            cnt_q   <= cnt_q - CW'(1);
         end
         if (finish) begin
            quotient_q  <= shreg_next;
            remainder_q <= r_next;
            done_q      <= 1'b1;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            dbz_q       <= 1'b0;
`endif
         end
`ifdef SEQ_DIV_ZERO_CHECK_EN
         // Same values the full algorithm would produce for a zero divisor.
         if (zero_done) begin
            quotient_q  <= '1;
            remainder_q <= bus.dividend[WIDTH-1:0];
            done_q      <= 1'b1;
            dbz_q       <= 1'b1;
         end
`endif
      end
   end

   assign bus.busy      = (state_q == RUN);
   assign bus.done      = done_q;
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
`ifdef SEQ_DIV_ZERO_CHECK_EN
   assign bus.div_by_zero = dbz_q;
`else
   assign bus.div_by_zero = 1'b0;
`endif

endmodule
